// File: rtl/lampfpu_fma_rounder.sv
// Rounding and packing back end of the FMA: rounds an unrounded, normalized
// significand to the selected mode, fixes up carry-out and exponent overflow,
// and emits the packed float plus exception flags.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   valid_i / ready_o              upstream handshake
//   sign_i, mant_i, exp_i          unrounded result (mant = carry,hidden,frac,G,R,S)
//   is_overflow_i, is_underflow_i  upstream exception classification
//   is_to_round_i                  0 = special value passthrough
//   rnd_mode_i                     00 RNE, 01 RTZ, 10 RUP, 11 RDN
//   valid_o / ready_i              downstream handshake
//   result_o                       {sign, exp, frac}
//   overflow_o, underflow_o, inexact_o  exception flags
module lampfpu_fma_rounder #(
    parameter int unsigned F_EXP  = 8,
    parameter int unsigned F_MANT = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      sign_i,
    input  logic [F_MANT+4:0]         mant_i,
    input  logic [F_EXP-1:0]          exp_i,
    input  logic                      is_overflow_i,
    input  logic                      is_underflow_i,
    input  logic                      is_to_round_i,
    input  logic [1:0]                rnd_mode_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [F_EXP+F_MANT:0]     result_o,
    output logic                      overflow_o,
    output logic                      underflow_o,
    output logic                      inexact_o
);

    localparam int unsigned SW = F_MANT + 2;
    localparam int unsigned RW = 1 + F_EXP + F_MANT;
    localparam int unsigned EW = F_EXP + 1;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    typedef enum logic [1:0] {CLS_NORM, CLS_PASS, CLS_OVF, CLS_UNF} cls_e;

    // Stage 1 registers
    logic              s1_valid_q, s1_valid_d;
    cls_e              s1_cls_q, s1_cls_d;
    logic              s1_sign_q, s1_sign_d;
    logic [F_EXP-1:0]  s1_exp_q, s1_exp_d;
    logic [SW-1:0]     s1_sig_q, s1_sig_d;
    logic              s1_inexact_q, s1_inexact_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic [F_MANT-1:0] s1_pfrac_q, s1_pfrac_d;

    // Stage 2 (output) registers
    logic              s2_valid_q, s2_valid_d;
    logic [RW-1:0]     result_q, result_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              inexact_q, inexact_d;

    logic s1_advance;
    logic s1_load;
    logic s2_load;

    assign s1_advance = !s2_valid_q || ready_i;
    assign ready_o    = !s1_valid_q || s1_advance;
    assign s1_load    = valid_i && ready_o;
    assign s2_load    = s1_valid_q && s1_advance;

    // S1: classify and round the significand
    always_comb begin
        logic inexact;
        logic inc;
        s1_valid_d   = s1_valid_q;
        s1_cls_d     = s1_cls_q;
        s1_sign_d    = s1_sign_q;
        s1_exp_d     = s1_exp_q;
        s1_sig_d     = s1_sig_q;
        s1_inexact_d = s1_inexact_q;
        s1_mode_d    = s1_mode_q;
        s1_pfrac_d   = s1_pfrac_q;
        inexact      = |mant_i[2:0];
        inc          = 1'b0;
        unique case (rnd_mode_i)
            RM_RNE: inc = mant_i[2] && (mant_i[1] || mant_i[0] || mant_i[3]);
            RM_RTZ: inc = 1'b0;
            RM_RUP: inc = inexact && !sign_i;
            RM_RDN: inc = inexact && sign_i;
            default: inc = 1'b0;
        endcase
        if (ready_o) begin
            s1_valid_d = valid_i;
        end
        if (s1_load) begin
            if (!is_to_round_i)     s1_cls_d = CLS_PASS;
            else if (is_overflow_i) s1_cls_d = CLS_OVF;
            else if (is_underflow_i) s1_cls_d = CLS_UNF;
            else                    s1_cls_d = CLS_NORM;
            s1_sign_d    = sign_i;
            s1_exp_d     = exp_i;
            s1_sig_d     = {1'b0, mant_i[F_MANT+3:3]} + SW'(inc);
            s1_inexact_d = inexact;
            s1_mode_d    = rnd_mode_i;
            s1_pfrac_d   = mant_i[F_MANT+4:5];
        end
    end

    // S2: exponent adjust, overflow saturation and packing
    always_comb begin
        logic             carry;
        logic [EW-1:0]    exp_r;
        logic             ovf_norm;
        logic             inf_sel;
        logic [F_EXP-1:0] exp_ones;
        logic [F_EXP-1:0] exp_max;
        logic [RW-1:0]    res_c;
        logic             ov_c, un_c, ix_c;
        s2_valid_d  = s2_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;
        exp_ones    = '1;
        exp_max     = {{(F_EXP-1){1'b1}}, 1'b0};
        carry       = s1_sig_q[SW-1];
        exp_r       = {1'b0, s1_exp_q} + EW'(carry);
        ovf_norm    = exp_r >= {1'b0, exp_ones};
        inf_sel     = (s1_mode_q == RM_RNE) ||
                      (s1_mode_q == RM_RUP && !s1_sign_q) ||
                      (s1_mode_q == RM_RDN && s1_sign_q);
        res_c = {s1_sign_q, exp_r[F_EXP-1:0], carry ? {F_MANT{1'b0}} : s1_sig_q[F_MANT-1:0]};
        ov_c  = 1'b0;
        un_c  = 1'b0;
        ix_c  = s1_inexact_q;
        if (s1_cls_q == CLS_PASS) begin
            res_c = {s1_sign_q, s1_exp_q, s1_pfrac_q};
            ix_c  = 1'b0;
        end else if (s1_cls_q == CLS_OVF || (s1_cls_q == CLS_NORM && ovf_norm)) begin
            res_c = inf_sel ? {s1_sign_q, exp_ones, {F_MANT{1'b0}}}
                            : {s1_sign_q, exp_max, {F_MANT{1'b1}}};
            ov_c  = 1'b1;
            ix_c  = 1'b1;
        end else if (s1_cls_q == CLS_UNF) begin
            res_c = {s1_sign_q, {(RW-1){1'b0}}};
            un_c  = 1'b1;
            ix_c  = 1'b1;
        end
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            result_d    = res_c;
            overflow_d  = ov_c;
            underflow_d = un_c;
            inexact_d   = ix_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_cls_q     <= CLS_NORM;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_sig_q     <= '0;
            s1_inexact_q <= 1'b0;
            s1_mode_q    <= '0;
            s1_pfrac_q   <= '0;
            s2_valid_q   <= 1'b0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            inexact_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cls_q     <= s1_cls_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_sig_q     <= s1_sig_d;
            s1_inexact_q <= s1_inexact_d;
            s1_mode_q    <= s1_mode_d;
            s1_pfrac_q   <= s1_pfrac_d;
            s2_valid_q   <= s2_valid_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            inexact_q    <= inexact_d;
        end
    end

    assign valid_o     = s2_valid_q;
    assign result_o    = result_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign inexact_o   = inexact_q;

endmodule

// File: tb/tb_lampfpu_fma_rounder.sv
// Scoreboard bench for lampfpu_fma_rounder: directed vectors with hand-computed
// results are queued at acceptance and checked by an independent monitor.
module tb_lampfpu_fma_rounder;

    logic        clk, rst;
    logic        valid_i, ready_o;
    logic        sign_i;
    logic [11:0] mant_i;
    logic [7:0]  exp_i;
    logic        is_overflow_i, is_underflow_i, is_to_round_i;
    logic [1:0]  rnd_mode_i;
    logic        valid_o, ready_i;
    logic [15:0] result_o;
    logic        overflow_o, underflow_o, inexact_o;

    lampfpu_fma_rounder dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o),
        .sign_i(sign_i), .mant_i(mant_i), .exp_i(exp_i),
        .is_overflow_i(is_overflow_i), .is_underflow_i(is_underflow_i),
        .is_to_round_i(is_to_round_i), .rnd_mode_i(rnd_mode_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .inexact_o(inexact_o)
    );

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        ov, un, ix;
        bit          lat;
        bit          consec;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_pop = -10;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: compare the head entry whenever an output is presented; pop on consume
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_output got %h want none", result_o);
            end else begin
                exp_t e;
                e = sb[0];
                n_vec++;
                if ({result_o, overflow_o, underflow_o, inexact_o} !== {e.res, e.ov, e.un, e.ix}) begin
                    n_err++;
                    $display("FAIL beat%0d got res=%h o/u/x=%b%b%b want res=%h o/u/x=%b%b%b",
                             e.id, result_o, overflow_o, underflow_o, inexact_o,
                             e.res, e.ov, e.un, e.ix);
                end
                if (ready_i) begin
                    if (e.lat) begin
                        n_vec++;
                        if (cyc - e.acc != 2) begin
                            n_err++;
                            $display("FAIL latency%0d got %0d want 2", e.id, cyc - e.acc);
                        end
                    end
                    if (e.consec) begin
                        n_vec++;
                        if (cyc != last_pop + 1) begin
                            n_err++;
                            $display("FAIL consec%0d got gap %0d want 1", e.id, cyc - last_pop);
                        end
                    end
                    last_pop = cyc;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic send(input int id, input logic s, input logic [7:0] e, input logic [11:0] m,
                        input logic tr, input logic ov, input logic un, input logic [1:0] md,
                        input logic [15:0] er, input logic eo, input logic eu, input logic ei,
                        input bit lat, input bit consec);
        bit acc;
        exp_t x;
        acc = 1'b0;
        valid_i = 1'b1; sign_i = s; exp_i = e; mant_i = m;
        is_to_round_i = tr; is_overflow_i = ov; is_underflow_i = un; rnd_mode_i = md;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (ready_o) begin
                acc = 1'b1;
                x.id = id; x.res = er; x.ov = eo; x.un = eu; x.ix = ei;
                x.lat = lat; x.consec = consec; x.acc = cyc;
                sb.push_back(x);
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept%0d got timeout want accepted", id);
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        sign_i = 1'b0; mant_i = '0; exp_i = '0;
        is_overflow_i = 1'b0; is_underflow_i = 1'b0; is_to_round_i = 1'b1; rnd_mode_i = 2'b00;
        #3;
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_flags", {overflow_o, underflow_o, inexact_o}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1 chk("rst_ready", ready_o, 1);
        @(posedge clk); #1;

        // Rounding, carry, overflow, passthrough and priority vectors
        send( 1, 0, 8'h7F, 12'h40C, 1, 0, 0, 2'b00, 16'h3F82, 0, 0, 1, 1, 0);
        send( 2, 0, 8'h7F, 12'h40C, 1, 0, 0, 2'b01, 16'h3F81, 0, 0, 1, 1, 0);
        send( 3, 0, 8'h7F, 12'h404, 1, 0, 0, 2'b00, 16'h3F80, 0, 0, 1, 1, 0);
        send( 4, 0, 8'h7F, 12'h7FE, 1, 0, 0, 2'b00, 16'h4000, 0, 0, 1, 1, 0);
        send( 5, 0, 8'hFE, 12'h7FE, 1, 0, 0, 2'b00, 16'h7F80, 1, 0, 1, 1, 0);
        send( 6, 0, 8'hFE, 12'h7FE, 1, 0, 0, 2'b01, 16'h7F7F, 0, 0, 1, 1, 0);
        send( 7, 1, 8'hFE, 12'h7FE, 1, 0, 0, 2'b10, 16'hFF7F, 0, 0, 1, 1, 0);
        send( 8, 1, 8'hFF, 12'h800, 0, 0, 0, 2'b00, 16'hFFC0, 0, 0, 0, 1, 0);
        send( 9, 1, 8'h01, 12'h400, 1, 0, 1, 2'b00, 16'h8000, 0, 1, 1, 1, 0);
        send(10, 0, 8'h00, 12'h000, 1, 0, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 0);
        send(11, 0, 8'h80, 12'h400, 1, 1, 0, 2'b10, 16'h7F80, 1, 0, 1, 1, 0);
        send(12, 1, 8'h80, 12'h400, 1, 1, 0, 2'b10, 16'hFF7F, 1, 0, 1, 1, 0);
        send(13, 1, 8'h80, 12'h400, 1, 1, 0, 2'b11, 16'hFF80, 1, 0, 1, 1, 0);
        send(14, 0, 8'h80, 12'h400, 1, 1, 0, 2'b11, 16'h7F7F, 1, 0, 1, 1, 0);
        send(15, 0, 8'h7F, 12'h401, 1, 0, 0, 2'b10, 16'h3F81, 0, 0, 1, 1, 0);
        send(16, 1, 8'h7F, 12'h401, 1, 0, 0, 2'b11, 16'hBF81, 0, 0, 1, 1, 0);
        send(17, 0, 8'h7F, 12'h401, 1, 0, 0, 2'b11, 16'h3F80, 0, 0, 1, 1, 0);
        send(18, 0, 8'h7F, 12'h408, 1, 0, 0, 2'b00, 16'h3F81, 0, 0, 0, 1, 0);
        send(19, 0, 8'h12, 12'h5A0, 0, 1, 0, 2'b00, 16'h092D, 0, 0, 0, 1, 0);
        send(20, 0, 8'h40, 12'h400, 1, 1, 1, 2'b00, 16'h7F80, 1, 0, 1, 1, 0);
        send(21, 1, 8'hFF, 12'h400, 1, 0, 0, 2'b00, 16'hFF80, 1, 0, 1, 1, 0);
        send(22, 1, 8'h80, 12'h400, 1, 1, 0, 2'b01, 16'hFF7F, 1, 0, 1, 1, 0);
        drain("drain_directed");

        // Backpressure: two accepts fill the pipe, third waits until release
        ready_i = 1'b0;
        send(31, 0, 8'h7F, 12'h40C, 1, 0, 0, 2'b00, 16'h3F82, 0, 0, 1, 0, 0);
        send(32, 0, 8'h7F, 12'h40C, 1, 0, 0, 2'b01, 16'h3F81, 0, 0, 1, 0, 1);
        chk("bp_ready_drop", ready_o, 0);
        fork
            send(33, 0, 8'h7F, 12'h7FE, 1, 0, 0, 2'b00, 16'h4000, 0, 0, 1, 0, 1);
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("bp_ready_held", ready_o, 0);
                chk("bp_valid_held", valid_o, 1);
                ready_i = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Reset with beats in flight
        send(41, 0, 8'h7F, 12'h40C, 1, 0, 0, 2'b00, 16'h3F82, 0, 0, 1, 1, 0);
        send(42, 0, 8'hFE, 12'h7FE, 1, 0, 0, 2'b00, 16'h7F80, 1, 0, 1, 1, 0);
        chk("pre_rst_valid", valid_o, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_result", result_o, 0);
        chk("mid_rst_flags", {overflow_o, underflow_o, inexact_o}, 0);
        sb.delete();
        @(negedge clk); rst = 1'b0;
        #1 chk("post_rst_ready", ready_o, 1);
        @(posedge clk); #1;
        send(43, 0, 8'h7F, 12'h404, 1, 0, 0, 2'b00, 16'h3F80, 0, 0, 1, 1, 0);
        drain("drain_after_reset");
        repeat (3) @(posedge clk);
        #1 chk("idle_valid", valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
